use_bit_pipe: RTL
=================

USE_BIT_PIPE -- requirements
Module: use_bit_pipe

Interface
REQ-001 Parameter NUM_WAYS, default 4, associativity; legal values are powers of two from 2 to 16.
REQ-002 Parameter NUM_SETS, default 64, number of status-array sets; SET_W = $clog2(NUM_SETS).
REQ-003 Derived SA_WORD_WIDTH = 2*NUM_WAYS; the field for way w is bits [2w+1:2w], where bit 2w+1 = use and bit 2w = valid.
REQ-004 i_clk  in  1  single clock, all logic rising-edge.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_req_valid  in  1  lookup-result request present.
REQ-007 o_req_ready  out  1  request accepted when i_req_valid & o_req_ready.
REQ-008 i_req_set  in  SET_W  set index of the request.
REQ-009 i_cache_hit  in  1  1 = hit, 0 = miss.
REQ-010 i_hit_blocks  in  NUM_WAYS  one-hot hit way; ignored when i_cache_hit=0.
REQ-011 o_sa_r_en / o_sa_r_addr  out  1 / SET_W  status-array read port; data arrives 1 cycle later.
REQ-012 i_sa_r_data  in  SA_WORD_WIDTH  read data; a same-cycle read and write to one address returns old data.
REQ-013 o_sa_w_en / o_sa_w_addr / o_sa_w_data / o_sa_w_mask  out  1 / SET_W / SA_WORD_WIDTH / NUM_WAYS  write port.
REQ-014 o_victim_valid / o_victim_way  out  1 / NUM_WAYS  one-hot replacement way for a miss.

Function
REQ-015 Two stages: S0 accepts the request and drives o_sa_r_en=1, o_sa_r_addr=i_req_set in the acceptance cycle t; S1 (cycle t+1) computes and drives results.
REQ-016 S1 effective use bits: eff = use & valid, taken per way; merged = eff | i_hit_blocks (registered).
REQ-017 If merged is all ones, new_use = hit_blocks (saturation reset); otherwise new_use = merged.
REQ-018 On a hit in S1: o_sa_w_en=1, o_sa_w_addr = set, o_sa_w_data = new_use in the use bits with valid bits copied from the read data, o_sa_w_mask = all ones.
REQ-019 On a miss in S1: o_sa_w_en=0 and o_victim_valid=1 for one cycle.
REQ-020 Victim priority:
- lowest-index invalid way;
- else lowest-index way with eff=0;
- else way 0.
REQ-021 o_victim_valid=0 on hits and on idle cycles; o_sa_w_en=0 on idle cycles.
REQ-022 One request per cycle, full throughput for distinct sets; latency is exactly 1 cycle from acceptance to write/victim.
REQ-023 Same-set back-to-back hazard (S1 writing set X while S0 accepts set X): handled per REQ-027/028.
REQ-024 With i_req_valid=0, o_sa_r_en=0.

Reset
REQ-025 While i_rst=1:
- S1 valid and the forwarding register are cleared;
- o_req_ready=0, o_sa_r_en=0, o_sa_w_en=0, o_victim_valid=0;
- all data/address outputs are 0.
REQ-026 A request accepted the cycle before reset asserts SHALL produce no write and no victim.

Configuration
REQ-027 With USE_BIT_FWD_EN defined: on a hazard, S1 of the second request uses the previous cycle's o_sa_w_data in place of i_sa_r_data; o_req_ready=1 whenever not in reset.
REQ-028 Without USE_BIT_FWD_EN: o_req_ready=0 when S1 holds a hit to i_req_set; the request is accepted the following cycle; no forwarding logic is present.

Structure
REQ-029 Package icache_pkg holds SA_BITS_PER_WAY=2, USE_BIT_OFS=1, VALID_BIT_OFS=0 and the way-field extraction function.
REQ-030 Combinational sub-module use_bit_policy (NUM_WAYS param) computes new_use and the victim; use_bit_pipe holds the pipeline, hazard and forwarding logic.

Verification (NUM_WAYS=4, NUM_SETS=64)
REQ-031 Reset: i_rst=1 for 2 cycles with i_req_valid=1 -> o_req_ready=0, o_sa_w_en=0, o_victim_valid=0.
REQ-032 Hit set 5, hit_blocks=4'b0100, read data 8'h5F -> t+1: w_en=1, addr=5, data=8'h7F, mask=4'hF.
REQ-033 Saturation: hit 4'b1000, read data 8'h7F -> data 8'hD5.
REQ-034 Misses: read 8'h7F -> no write, victim 4'b1000; read 8'hFC -> victim 4'b0001; read 8'hFF -> victim 4'b0001.
REQ-035 Same set 5 back-to-back (hit 4'b0100 then hit 4'b1000, SRAM returns 8'h5F both times):
- FWD_EN: writes 8'h7F then 8'hD5 on consecutive cycles;
- no FWD_EN: ready=0 for one cycle, then the second write is 8'hD5.
REQ-036 Reset asserted the cycle after accepting a hit -> no write observed.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared status-array layout constants and way-field helpers for the I-cache use-bit logic.
package icache_pkg;

  localparam int unsigned SA_BITS_PER_WAY = 2;
  localparam int unsigned USE_BIT_OFS     = 1;
  localparam int unsigned VALID_BIT_OFS   = 0;

  // Widest supported status word; the helper works on a zero-extended copy.
  localparam int unsigned MAX_WAYS      = 16;
  localparam int unsigned MAX_SA_WORD_W = MAX_WAYS * SA_BITS_PER_WAY;
  localparam int unsigned WAY_IDX_W     = $clog2(MAX_WAYS);

  typedef logic [SA_BITS_PER_WAY-1:0] way_field_t;

  // Extract the {use, valid} field of one way from a status word.
  function automatic way_field_t get_way_field(
    input logic [MAX_SA_WORD_W-1:0] word,
    input logic [WAY_IDX_W-1:0]     way
  );
    return word[{way, 1'b0} +: SA_BITS_PER_WAY];
  endfunction

endpackage : icache_pkg

// File: rtl/use_bit_policy.sv
// Combinational use-bit update and victim selection for one status-array word.
module use_bit_policy
  import icache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  localparam int unsigned SA_WORD_WIDTH = SA_BITS_PER_WAY * NUM_WAYS
) (
  input  logic [SA_WORD_WIDTH-1:0] sa_word_i,
  input  logic [NUM_WAYS-1:0]      hit_blocks_i,
  output logic [SA_WORD_WIDTH-1:0] new_word_o,
  output logic [NUM_WAYS-1:0]      victim_o
);

  logic [NUM_WAYS-1:0] valid_vec;
  logic [NUM_WAYS-1:0] eff_vec;
  logic [NUM_WAYS-1:0] merged_vec;
  logic [NUM_WAYS-1:0] new_use_vec;
  way_field_t          field;
  logic                found;

  // Split the word into per-way valid and effective-use vectors.
  always_comb begin
    valid_vec = '0;
    eff_vec   = '0;
    field     = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      field        = get_way_field(MAX_SA_WORD_W'(sa_word_i), WAY_IDX_W'(w));
      valid_vec[w] = field[VALID_BIT_OFS];
      eff_vec[w]   = field[USE_BIT_OFS] & field[VALID_BIT_OFS];
    end
  end

  // Merge the hit into the use bits; a full set of use bits collapses to the hit way.
  always_comb begin
    merged_vec  = eff_vec | hit_blocks_i;
    new_use_vec = (&merged_vec) ? hit_blocks_i : merged_vec;
  end

  // Repack the new use bits with the original valid bits.
  always_comb begin
    new_word_o = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      new_word_o[w*SA_BITS_PER_WAY + USE_BIT_OFS]   = new_use_vec[w];
      new_word_o[w*SA_BITS_PER_WAY + VALID_BIT_OFS] = valid_vec[w];
    end
  end

  // Victim: first invalid way, else first way without effective use, else way 0.
  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_vec[w]) begin
        victim_o[w] = 1'b1;
        found       = 1'b1;
      end
    end
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!found && !eff_vec[w]) begin
        victim_o[w] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) begin
      victim_o[0] = 1'b1;
    end
  end

endmodule : use_bit_policy

// File: rtl/use_bit_pipe.sv
// Two-stage use-bit pipeline: S0 issues the status-array read, S1 updates use
// bits on a hit or nominates a victim on a miss.
// Build option: define USE_BIT_FWD_EN to forward the previous write into S1 on a
// same-set back-to-back request instead of stalling the second request.
module use_bit_pipe
  import icache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned NUM_SETS = 64,
  localparam int unsigned SET_W = $clog2(NUM_SETS),
  localparam int unsigned SA_WORD_WIDTH = SA_BITS_PER_WAY * NUM_WAYS
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [SET_W-1:0]         i_req_set,
  input  logic                     i_cache_hit,
  input  logic [NUM_WAYS-1:0]      i_hit_blocks,
  output logic                     o_sa_r_en,
  output logic [SET_W-1:0]         o_sa_r_addr,
  input  logic [SA_WORD_WIDTH-1:0] i_sa_r_data,
  output logic                     o_sa_w_en,
  output logic [SET_W-1:0]         o_sa_w_addr,
  output logic [SA_WORD_WIDTH-1:0] o_sa_w_data,
  output logic [NUM_WAYS-1:0]      o_sa_w_mask,
  output logic                     o_victim_valid,
  output logic [NUM_WAYS-1:0]      o_victim_way
);

  logic                     accept_c;
  logic                     hazard_c;
  logic                     s1_write_c;
  logic                     s1_miss_c;
  logic [SA_WORD_WIDTH-1:0] s1_word_c;
  logic [SA_WORD_WIDTH-1:0] new_word_c;
  logic [NUM_WAYS-1:0]      victim_c;

  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_hit_q, s1_hit_d;
  logic [SET_W-1:0]         s1_set_q, s1_set_d;
  logic [NUM_WAYS-1:0]      s1_hit_blocks_q, s1_hit_blocks_d;

  // S0 handshake and read issue; a hit in S1 to the same set is the hazard.
  always_comb begin
    hazard_c = s1_valid_q && s1_hit_q && (s1_set_q == i_req_set);
`ifdef USE_BIT_FWD_EN
    o_req_ready = !i_rst;
`else
    o_req_ready = !i_rst && !hazard_c;
`endif
    accept_c    = i_req_valid && o_req_ready;
    o_sa_r_en   = accept_c;
    o_sa_r_addr = accept_c ? i_req_set : '0;
  end

  // Capture the accepted request into S1; miss requests carry no hit ways.
  always_comb begin
    s1_valid_d      = accept_c;
    s1_hit_d        = s1_hit_q;
    s1_set_d        = s1_set_q;
    s1_hit_blocks_d = s1_hit_blocks_q;
    if (accept_c) begin
      s1_hit_d        = i_cache_hit;
      s1_set_d        = i_req_set;
      s1_hit_blocks_d = i_cache_hit ? i_hit_blocks : '0;
    end
  end

  // S1 pipeline registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q      <= 1'b0;
      s1_hit_q        <= 1'b0;
      s1_set_q        <= '0;
      s1_hit_blocks_q <= '0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_hit_q        <= s1_hit_d;
      s1_set_q        <= s1_set_d;
      s1_hit_blocks_q <= s1_hit_blocks_d;
    end
  end

`ifdef USE_BIT_FWD_EN
  logic                     fwd_valid_q, fwd_valid_d;
  logic [SA_WORD_WIDTH-1:0] fwd_data_q, fwd_data_d;

  // Remember the word being written when the same set is accepted behind it.
  always_comb begin
    fwd_valid_d = accept_c && hazard_c;
    fwd_data_d  = fwd_valid_d ? o_sa_w_data : fwd_data_q;
  end

  // Forwarding register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  // The array returns stale data on a same-cycle read/write, so prefer the forwarded word.
  assign s1_word_c = fwd_valid_q ? fwd_data_q : i_sa_r_data;
`else
  assign s1_word_c = i_sa_r_data;
`endif

  use_bit_policy #(
    .NUM_WAYS (NUM_WAYS)
  ) u_policy (
    .sa_word_i    (s1_word_c),
    .hit_blocks_i (s1_hit_blocks_q),
    .new_word_o   (new_word_c),
    .victim_o     (victim_c)
  );

  // S1 results: write-back on a hit, victim on a miss, everything quiet in reset.
  always_comb begin
    s1_write_c     = !i_rst && s1_valid_q && s1_hit_q;
    s1_miss_c      = !i_rst && s1_valid_q && !s1_hit_q;
    o_sa_w_en      = s1_write_c;
    o_sa_w_addr    = s1_write_c ? s1_set_q : '0;
    o_sa_w_data    = s1_write_c ? new_word_c : '0;
    o_sa_w_mask    = s1_write_c ? {NUM_WAYS{1'b1}} : '0;
    o_victim_valid = s1_miss_c;
    o_victim_way   = s1_miss_c ? victim_c : '0;
  end

endmodule : use_bit_pipe
